// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a start/busy/done handshake, a retained
// CLFZN flag register, carry-in chaining, an iterative one-bit-per-cycle
// shifter and a shift-add multiplier.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for start; single-cycle ops complete from here
//   RUN   | iterating a shift or multiply; cnt_q counts remaining steps
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic [4:0]       CLFZN,
  output logic             busy,
  output logic             done,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_LSL  = 4'd8;
  localparam logic [3:0] OP_LSR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_MOV  = 4'd12;

  localparam logic [SHW:0] CNT_MUL = WIDTH[SHW:0];

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] s_q;
  logic [4:0]       flags_q;
  logic             busy_q, done_q, illegal_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] hi_q;
  logic [SHW:0]     cnt_q;

  assign S       = s_q;
  assign CLFZN   = flags_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;

  // Shared adder/subtractor for the single-cycle arithmetic ops
  logic             cin;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic             add_v, sub_v;

  assign cin      = (opcode == OP_ADDC) ? flags_q[4] : 1'b0;
  assign sum_ext  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin};
  assign diff_ext = {1'b0, A} - {1'b0, B};
  assign add_v    = (A[MSB] == B[MSB]) && (sum_ext[MSB] != A[MSB]);
  assign sub_v    = (A[MSB] != B[MSB]) && (diff_ext[MSB] != A[MSB]);

  logic [WIDTH-1:0] sc_res;
  logic [4:0]       sc_flags;
  logic             sc_multi, sc_ill, sc_zn;

  // Decode the issued opcode: single-cycle result/flags, or flag a multi-cycle op
  always_comb begin
    sc_res   = s_q;
    sc_flags = flags_q;
    sc_multi = 1'b0;
    sc_ill   = 1'b0;
    sc_zn    = 1'b0;
    case (opcode)
      OP_ADD, OP_ADDC: begin
        sc_res   = sum_ext[WIDTH-1:0];
        sc_flags = {sum_ext[WIDTH], 1'b0, add_v, sum_ext[WIDTH-1:0] == '0, sum_ext[MSB]};
      end
      OP_SUB, OP_CMP: begin
        // N reports signed less-than, so the overflow case flips the sign bit
        if (opcode == OP_SUB) sc_res = diff_ext[WIDTH-1:0];
        sc_flags = {diff_ext[WIDTH], diff_ext[WIDTH], sub_v,
                    diff_ext[WIDTH-1:0] == '0, diff_ext[MSB] ^ sub_v};
      end
      OP_AND: begin sc_res = A & B; sc_zn = 1'b1; end
      OP_OR:  begin sc_res = A | B; sc_zn = 1'b1; end
      OP_XOR: begin sc_res = A ^ B; sc_zn = 1'b1; end
      OP_NOT: begin sc_res = ~A;    sc_zn = 1'b1; end
      OP_LSL, OP_LSR, OP_ASR: begin
        // A zero-length shift is a plain pass-through and needs no iteration
        if (B[SHW-1:0] == '0) begin
          sc_res = A;
          sc_zn  = 1'b1;
        end else begin
          sc_multi = 1'b1;
        end
      end
      OP_MUL: sc_multi = 1'b1;
      OP_MOV: sc_res = B;
      default: begin
        sc_res = '0;
        sc_ill = 1'b1;
      end
    endcase
    if (sc_zn) sc_flags[1:0] = {sc_res == '0, sc_res[MSB]};
  end

  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] it_work, it_hi;
  logic [4:0]       fin_flags;

  // One iteration step; the multiplier keeps {hi_q, work_q} as the partial product
  always_comb begin
    mul_add = {1'b0, hi_q} + (work_q[0] ? {1'b0, opa_q} : {(WIDTH+1){1'b0}});
    it_work = work_q;
    it_hi   = hi_q;
    case (op_q)
      OP_LSL: it_work = {work_q[WIDTH-2:0], 1'b0};
      OP_LSR: it_work = {1'b0, work_q[WIDTH-1:1]};
      OP_ASR: it_work = {work_q[MSB], work_q[WIDTH-1:1]};
      OP_MUL: begin
        it_hi   = mul_add[WIDTH:1];
        it_work = {mul_add[0], work_q[WIDTH-1:1]};
      end
      default: ;
    endcase
    fin_flags      = flags_q;
    fin_flags[1:0] = {it_work == '0, it_work[MSB]};
    if (op_q == OP_MUL) fin_flags[4] = |it_hi;
  end

  // Handshake FSM with registered result, flags and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      flags_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      op_q      <= '0;
      opa_q     <= '0;
      work_q    <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q    <= 1'b0;
          illegal_q <= 1'b0;
          if (start) begin
            if (sc_multi) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              op_q    <= opcode;
              opa_q   <= A;
              hi_q    <= '0;
              if (opcode == OP_MUL) begin
                work_q <= B;
                cnt_q  <= CNT_MUL;
              end else begin
                work_q <= A;
                cnt_q  <= {1'b0, B[SHW-1:0]};
              end
            end else begin
              s_q       <= sc_res;
              flags_q   <= sc_flags;
              done_q    <= 1'b1;
              illegal_q <= sc_ill;
            end
          end
        end
        RUN: begin
          work_q <= it_work;
          hi_q   <= it_hi;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == {{SHW{1'b0}}, 1'b1}) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            s_q     <= it_work;
            flags_q <= fin_flags;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios followed by random
// operations, all compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk, reset, start;
  logic [3:0]   opcode;
  logic [W-1:0] A, B, S;
  logic [4:0]   CLFZN;
  logic         busy, done, illegal;

  int checks = 0;
  int errors = 0;

  // reference model state and expectations for the op in flight
  logic [W-1:0] m_s;
  logic [4:0]   m_f;
  logic [W-1:0] exp_s;
  logic [4:0]   exp_f;
  int           exp_lat;
  logic         exp_ill;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .A(A), .B(B), .S(S), .CLFZN(CLFZN),
    .busy(busy), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected outcome computed from the operation definitions with plain integers
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, r;
    int     sa, sb, ss, amt;
    logic   c;
    logic [4:0] f;
    ua = longint'(a); ub = longint'(b);
    sa = $signed(a);  sb = $signed(b);
    amt = int'(b[3:0]);
    c = m_f[4];
    f = m_f;
    exp_s = m_s; exp_lat = 1; exp_ill = 1'b0;
    case (op)
      4'd0, 4'd1: begin
        r  = ua + ub + ((op == 4'd1 && c) ? 64'sd1 : 64'sd0);
        ss = sa + sb + ((op == 4'd1 && c) ? 1 : 0);
        exp_s = r[W-1:0];
        f = {(r > 65535), 1'b0, (ss > 32767 || ss < -32768), (exp_s == 0), exp_s[W-1]};
      end
      4'd2, 4'd3: begin
        ss = sa - sb;
        if (op == 4'd2) exp_s = a - b;
        f = {(ua < ub), (ua < ub), (ss > 32767 || ss < -32768), (a == b), (sa < sb)};
      end
      4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
        case (op)
          4'd4: exp_s = a & b;
          4'd5: exp_s = a | b;
          4'd6: exp_s = a ^ b;
          4'd7: exp_s = ~a;
          4'd8: begin exp_s = a << amt; exp_lat = amt + 1; end
          4'd9: begin exp_s = a >> amt; exp_lat = amt + 1; end
          4'd10: begin exp_s = 16'(sa >>> amt); exp_lat = amt + 1; end
          default: begin
            r = ua * ub;
            exp_s = r[W-1:0];
            f[4] = (r > 65535);
            exp_lat = W + 1;
          end
        endcase
        f[1] = (exp_s == 0);
        f[0] = exp_s[W-1];
      end
      4'd12: exp_s = b;
      default: begin exp_s = '0; exp_ill = 1'b1; end
    endcase
    exp_f = f;
  endtask

  // Present an op for one accepting edge; returns at the negedge of cycle 1
  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    model(op, a, b);
    start = 1'b1; opcode = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    opcode = 4'($urandom); A = 16'($urandom); B = 16'($urandom);
  endtask

  // Follow the op to its done cycle; inj>0 raises an ADD start in that busy cycle
  task automatic finish_op(input int inj);
    int  k, busy_cnt;
    bit  got;
    got = 0; busy_cnt = 0; k = 1;
    while (k <= 40 && !got) begin
      if (inj > 0 && k == inj + 1) start = 1'b0;
      if (inj > 0 && k == inj) begin start = 1'b1; opcode = 4'd0; A = 16'h0001; B = 16'h0001; end
      if (done) got = 1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      check("done_timeout", 32'(done), 32'd1);
    end else begin
      check("latency", 32'(k), 32'(exp_lat));
      check("busy_cycles", 32'(busy_cnt), 32'(exp_lat - 1));
      check("busy_at_done", 32'(busy), 32'd0);
      check("S", 32'(S), 32'(exp_s));
      check("CLFZN", 32'(CLFZN), 32'(exp_f));
      check("illegal", 32'(illegal), 32'(exp_ill));
    end
    m_s = exp_s;
    m_f = exp_f;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit b2b, input int inj);
    if (!b2b) begin
      @(negedge clk);
      check("done_single_pulse", 32'(done), 32'd0);
    end
    start_op(op, a, b);
    finish_op(inj);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; opcode = '0; A = '0; B = '0;
    m_s = '0; m_f = '0;
    repeat (3) @(negedge clk);
    check("rst_S", 32'(S), 32'd0);
    check("rst_CLFZN", 32'(CLFZN), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;

    run_op(4'd0, 16'h7FFF, 16'h0001, 1'b0, 0);
    check("plan_add_S", 32'(S), 32'h8000);
    check("plan_add_flags", 32'(CLFZN), 32'b00101);

    run_op(4'd2, 16'h0003, 16'h0005, 1'b0, 0);
    check("plan_sub_flags", 32'(CLFZN), 32'b11001);
    run_op(4'd3, 16'h0005, 16'h0005, 1'b0, 0);
    check("plan_cmp_S", 32'(S), 32'hFFFE);
    check("plan_cmp_flags", 32'(CLFZN), 32'b00010);

    run_op(4'd0, 16'hFFFF, 16'h0001, 1'b0, 0);
    check("plan_carry_flags", 32'(CLFZN), 32'b10010);
    run_op(4'd1, 16'h0000, 16'h0000, 1'b1, 0);
    check("plan_addc_S", 32'(S), 32'h0001);

    run_op(4'd11, 16'h00FF, 16'h0101, 1'b0, 5);
    check("plan_mul_S", 32'(S), 32'hFFFF);
    run_op(4'd11, 16'h8000, 16'h0002, 1'b0, 0);
    check("plan_mul_hi_flags", 32'(CLFZN), 32'b10010);

    run_op(4'd10, 16'h8000, 16'h0004, 1'b0, 0);
    check("plan_asr_S", 32'(S), 32'hF800);
    run_op(4'd8, 16'h1234, 16'h0000, 1'b0, 0);

    // reset in cycle 8 of a multiply: no done, everything cleared
    @(negedge clk);
    start_op(4'd11, 16'h1234, 16'h5678);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_S", 32'(S), 32'd0);
    check("abort_CLFZN", 32'(CLFZN), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    m_s = '0; m_f = '0;

    run_op(4'd2, 16'h0001, 16'h0002, 1'b0, 0);
    run_op(4'd14, 16'hAAAA, 16'h5555, 1'b0, 0);
    check("plan_illegal_S", 32'(S), 32'd0);

    for (int n = 0; n < 80; n++) begin
      run_op(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             bit'($urandom_range(0, 1)), 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
